// File: rtl/rs_alu_station_pkg.sv
// Shared types for the ALU reservation station: operand/entry records plus the
// core-wide ALU opcode, flag and width definitions the station consumes.
package rs_alu_station_pkg;

    localparam int unsigned GPR_SIZE        = 32;
    localparam int unsigned ROB_IDX_SIZE    = 4;
    localparam int unsigned RS_SIZE_DEFAULT = 4;

    typedef enum logic [3:0] {
        ALU_PLUS  = 4'd0,
        ALU_MINUS = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_LSL   = 4'd5,
        ALU_LSR   = 4'd6,
        ALU_MOV   = 4'd7
    } alu_op_t;

    typedef logic [3:0] nzcv_t;

    // The NZCV slot reuses the GPR-wide value field; flags live in bits [3:0].
    typedef struct packed {
        logic                    ready;
        logic [ROB_IDX_SIZE-1:0] tag;
        logic [GPR_SIZE-1:0]     value;
    } rs_operand_t;

    typedef struct packed {
        alu_op_t                 op;
        logic [ROB_IDX_SIZE-1:0] dst;
        logic                    set_nzcv;
        rs_operand_t             a;
        rs_operand_t             b;
        rs_operand_t             nzcv;
    } rs_entry_t;

endpackage

// File: rtl/rs_alu_station_if.sv
// Dispatch, result-broadcast and functional-unit issue signals of the ALU
// reservation station; slave is the station, master is whoever drives it.
interface rs_alu_station_if
    import rs_alu_station_pkg::*;
#(
    parameter int unsigned RS_SIZE = RS_SIZE_DEFAULT
);

    logic                      in_flush;

    logic                      in_disp_valid;
    logic                      out_disp_ready;
    alu_op_t                   in_disp_op;
    logic [GPR_SIZE-1:0]       in_disp_val_a;
    logic [GPR_SIZE-1:0]       in_disp_val_b;
    logic                      in_disp_a_ready;
    logic                      in_disp_b_ready;
    logic [ROB_IDX_SIZE-1:0]   in_disp_a_tag;
    logic [ROB_IDX_SIZE-1:0]   in_disp_b_tag;
    nzcv_t                     in_disp_nzcv;
    logic                      in_disp_nzcv_ready;
    logic [ROB_IDX_SIZE-1:0]   in_disp_nzcv_tag;
    logic                      in_disp_set_nzcv;
    logic [ROB_IDX_SIZE-1:0]   in_disp_dst_rob_index;

    logic                      in_cdb_done;
    logic [ROB_IDX_SIZE-1:0]   in_cdb_rob_index;
    logic [GPR_SIZE-1:0]       in_cdb_value;
    logic                      in_cdb_set_nzcv;
    nzcv_t                     in_cdb_nzcv;

    logic                      in_fu_ready;
    logic                      out_fu_start;
    alu_op_t                   out_fu_op;
    logic [GPR_SIZE-1:0]       out_fu_val_a;
    logic [GPR_SIZE-1:0]       out_fu_val_b;
    logic [ROB_IDX_SIZE-1:0]   out_fu_dst_rob_index;
    logic                      out_fu_set_nzcv;
    nzcv_t                     out_fu_nzcv;

    logic [$clog2(RS_SIZE):0]  out_count;

    modport master (
        output in_flush,
        output in_disp_valid, in_disp_op, in_disp_val_a, in_disp_val_b,
        output in_disp_a_ready, in_disp_b_ready, in_disp_a_tag, in_disp_b_tag,
        output in_disp_nzcv, in_disp_nzcv_ready, in_disp_nzcv_tag,
        output in_disp_set_nzcv, in_disp_dst_rob_index,
        output in_cdb_done, in_cdb_rob_index, in_cdb_value, in_cdb_set_nzcv, in_cdb_nzcv,
        output in_fu_ready,
        input  out_disp_ready,
        input  out_fu_start, out_fu_op, out_fu_val_a, out_fu_val_b,
        input  out_fu_dst_rob_index, out_fu_set_nzcv, out_fu_nzcv,
        input  out_count
    );

    modport slave (
        input  in_flush,
        input  in_disp_valid, in_disp_op, in_disp_val_a, in_disp_val_b,
        input  in_disp_a_ready, in_disp_b_ready, in_disp_a_tag, in_disp_b_tag,
        input  in_disp_nzcv, in_disp_nzcv_ready, in_disp_nzcv_tag,
        input  in_disp_set_nzcv, in_disp_dst_rob_index,
        input  in_cdb_done, in_cdb_rob_index, in_cdb_value, in_cdb_set_nzcv, in_cdb_nzcv,
        input  in_fu_ready,
        output out_disp_ready,
        output out_fu_start, out_fu_op, out_fu_val_a, out_fu_val_b,
        output out_fu_dst_rob_index, out_fu_set_nzcv, out_fu_nzcv,
        output out_count
    );

endinterface

// File: rtl/rs_operand_wakeup.sv
// Tag compare and value capture for one operand slot against the result
// broadcast; in_enable gates the match (used for the flags slot).
module rs_operand_wakeup
    import rs_alu_station_pkg::*;
(
    input  rs_operand_t              in_operand,
    input  logic                     in_cdb_done,
    input  logic                     in_enable,
    input  logic [ROB_IDX_SIZE-1:0]  in_cdb_rob_index,
    input  logic [GPR_SIZE-1:0]      in_cdb_value,
    output rs_operand_t              out_operand
);

    logic hit;

    assign hit = in_cdb_done && in_enable && !in_operand.ready
                 && (in_operand.tag == in_cdb_rob_index);

    always_comb begin
        out_operand = in_operand;
        if (hit) begin
            out_operand.ready = 1'b1;
            out_operand.value = in_cdb_value;
        end
    end

endmodule

// File: rtl/rs_alu_station.sv
// ALU reservation station: collapsing queue (index 0 oldest) that snoops the
// result bus for wakeup and issues the oldest fully-ready entry to the ALU.
module rs_alu_station
    import rs_alu_station_pkg::*;
#(
    parameter int unsigned RS_SIZE = RS_SIZE_DEFAULT
) (
    input logic              in_clk,
    input logic              in_rst_n,
    rs_alu_station_if.slave  bus
);

    localparam int unsigned IDX_W = $clog2(RS_SIZE);
    localparam int unsigned CNT_W = IDX_W + 1;

    rs_entry_t               entries      [RS_SIZE];
    rs_entry_t               woken        [RS_SIZE];
    rs_entry_t               next_entries [RS_SIZE];
    rs_entry_t               disp_entry;
    rs_operand_t             disp_a, disp_b, disp_n;
    rs_operand_t             disp_wa, disp_wb, disp_wn;
    logic [RS_SIZE-1:0]      valid;
    logic [CNT_W-1:0]        count, count_next, wr_idx;
    logic [IDX_W-1:0]        issue_idx;
    logic                    issue_valid, disp_fire, disp_ready;
    logic [GPR_SIZE-1:0]     cdb_nzcv_word;

    alu_op_t                 sel_op;
    logic [GPR_SIZE-1:0]     sel_val_a, sel_val_b;
    logic [ROB_IDX_SIZE-1:0] sel_dst;
    logic                    sel_set_nzcv;
    nzcv_t                   sel_nzcv;

    logic                    fu_start, fu_set_nzcv;
    alu_op_t                 fu_op;
    logic [GPR_SIZE-1:0]     fu_val_a, fu_val_b;
    logic [ROB_IDX_SIZE-1:0] fu_dst;
    nzcv_t                   fu_nzcv;

    assign cdb_nzcv_word = GPR_SIZE'(bus.in_cdb_nzcv);

    for (genvar g = 0; g < RS_SIZE; g++) begin : g_slot
        rs_operand_t w_a, w_b, w_n;

        assign valid[g] = (CNT_W'(g) < count);

        rs_operand_wakeup u_wake_a (
            .in_operand       (entries[g].a),
            .in_cdb_done      (bus.in_cdb_done),
            .in_enable        (1'b1),
            .in_cdb_rob_index (bus.in_cdb_rob_index),
            .in_cdb_value     (bus.in_cdb_value),
            .out_operand      (w_a)
        );
        rs_operand_wakeup u_wake_b (
            .in_operand       (entries[g].b),
            .in_cdb_done      (bus.in_cdb_done),
            .in_enable        (1'b1),
            .in_cdb_rob_index (bus.in_cdb_rob_index),
            .in_cdb_value     (bus.in_cdb_value),
            .out_operand      (w_b)
        );
        rs_operand_wakeup u_wake_n (
            .in_operand       (entries[g].nzcv),
            .in_cdb_done      (bus.in_cdb_done),
            .in_enable        (bus.in_cdb_set_nzcv),
            .in_cdb_rob_index (bus.in_cdb_rob_index),
            .in_cdb_value     (cdb_nzcv_word),
            .out_operand      (w_n)
        );

        assign woken[g] = '{op: entries[g].op, dst: entries[g].dst,
                            set_nzcv: entries[g].set_nzcv,
                            a: w_a, b: w_b, nzcv: w_n};
    end

    // Same-cycle bypass so a dispatch matching the current broadcast lands ready.
    assign disp_a = '{ready: bus.in_disp_a_ready, tag: bus.in_disp_a_tag,
                      value: bus.in_disp_val_a};
    assign disp_b = '{ready: bus.in_disp_b_ready, tag: bus.in_disp_b_tag,
                      value: bus.in_disp_val_b};
    assign disp_n = '{ready: bus.in_disp_nzcv_ready, tag: bus.in_disp_nzcv_tag,
                      value: GPR_SIZE'(bus.in_disp_nzcv)};

    rs_operand_wakeup u_byp_a (
        .in_operand       (disp_a),
        .in_cdb_done      (bus.in_cdb_done),
        .in_enable        (1'b1),
        .in_cdb_rob_index (bus.in_cdb_rob_index),
        .in_cdb_value     (bus.in_cdb_value),
        .out_operand      (disp_wa)
    );
    rs_operand_wakeup u_byp_b (
        .in_operand       (disp_b),
        .in_cdb_done      (bus.in_cdb_done),
        .in_enable        (1'b1),
        .in_cdb_rob_index (bus.in_cdb_rob_index),
        .in_cdb_value     (bus.in_cdb_value),
        .out_operand      (disp_wb)
    );
    rs_operand_wakeup u_byp_n (
        .in_operand       (disp_n),
        .in_cdb_done      (bus.in_cdb_done),
        .in_enable        (bus.in_cdb_set_nzcv),
        .in_cdb_rob_index (bus.in_cdb_rob_index),
        .in_cdb_value     (cdb_nzcv_word),
        .out_operand      (disp_wn)
    );

    assign disp_entry = '{op: bus.in_disp_op, dst: bus.in_disp_dst_rob_index,
                          set_nzcv: bus.in_disp_set_nzcv,
                          a: disp_wa, b: disp_wb, nzcv: disp_wn};

    assign disp_ready = (count < CNT_W'(RS_SIZE));
    assign disp_fire  = bus.in_disp_valid && disp_ready;
    assign wr_idx     = issue_valid ? (count - 1'b1) : count;

    // Selection looks only at registered readiness; wakeups count from next cycle.
    always_comb begin
        issue_valid  = 1'b0;
        issue_idx    = '0;
        sel_op       = entries[0].op;
        sel_val_a    = entries[0].a.value;
        sel_val_b    = entries[0].b.value;
        sel_dst      = entries[0].dst;
        sel_set_nzcv = entries[0].set_nzcv;
        sel_nzcv     = entries[0].nzcv.value[3:0];
        for (int unsigned i = 0; i < RS_SIZE; i++) begin
            if (!issue_valid && bus.in_fu_ready && valid[i] && entries[i].a.ready
                && entries[i].b.ready && entries[i].nzcv.ready) begin
                issue_valid  = 1'b1;
                issue_idx    = IDX_W'(i);
                sel_op       = entries[i].op;
                sel_val_a    = entries[i].a.value;
                sel_val_b    = entries[i].b.value;
                sel_dst      = entries[i].dst;
                sel_set_nzcv = entries[i].set_nzcv;
                sel_nzcv     = entries[i].nzcv.value[3:0];
            end
        end
    end

    always_comb begin
        next_entries = woken;
        for (int unsigned i = 0; i + 1 < RS_SIZE; i++) begin
            if (issue_valid && IDX_W'(i) >= issue_idx) begin
                next_entries[i] = woken[i + 1];
            end
        end
        if (issue_valid) begin
            next_entries[RS_SIZE-1] = '0;
        end
        for (int unsigned i = 0; i < RS_SIZE; i++) begin
            if (disp_fire && CNT_W'(i) == wr_idx) begin
                next_entries[i] = disp_entry;
            end
        end
    end

    always_comb begin
        count_next = count;
        if (disp_fire && !issue_valid) begin
            count_next = count + 1'b1;
        end else if (!disp_fire && issue_valid) begin
            count_next = count - 1'b1;
        end
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            entries     <= '{default: '0};
            count       <= '0;
            fu_start    <= 1'b0;
            fu_op       <= ALU_PLUS;
            fu_val_a    <= '0;
            fu_val_b    <= '0;
            fu_dst      <= '0;
            fu_set_nzcv <= 1'b0;
            fu_nzcv     <= '0;
        end else if (bus.in_flush) begin
            count    <= '0;
            fu_start <= 1'b0;
        end else begin
            entries  <= next_entries;
            count    <= count_next;
            fu_start <= issue_valid;
            if (issue_valid) begin
                fu_op       <= sel_op;
                fu_val_a    <= sel_val_a;
                fu_val_b    <= sel_val_b;
                fu_dst      <= sel_dst;
                fu_set_nzcv <= sel_set_nzcv;
                fu_nzcv     <= sel_nzcv;
            end
        end
    end

    assign bus.out_disp_ready       = disp_ready;
    assign bus.out_count            = count;
    assign bus.out_fu_start         = fu_start;
    assign bus.out_fu_op            = fu_op;
    assign bus.out_fu_val_a         = fu_val_a;
    assign bus.out_fu_val_b         = fu_val_b;
    assign bus.out_fu_dst_rob_index = fu_dst;
    assign bus.out_fu_set_nzcv      = fu_set_nzcv;
    assign bus.out_fu_nzcv          = fu_nzcv;

endmodule

// File: tb/tb_rs_alu_station.sv
// Scoreboard bench for rs_alu_station: a queue-based reference model predicts
// each issue; a negedge monitor compares whatever the station presents.
module tb_rs_alu_station;
    import rs_alu_station_pkg::*;

    localparam int unsigned N = 4;

    logic in_clk   = 1'b0;
    logic in_rst_n = 1'b0;
    always #5 in_clk = ~in_clk;

    rs_alu_station_if #(.RS_SIZE(N)) bus ();

    rs_alu_station #(.RS_SIZE(N)) dut (
        .in_clk   (in_clk),
        .in_rst_n (in_rst_n),
        .bus      (bus.slave)
    );

    typedef struct packed {
        logic                     flush;
        logic                     disp_valid;
        alu_op_t                  op;
        logic [GPR_SIZE-1:0]      val_a;
        logic [GPR_SIZE-1:0]      val_b;
        logic                     a_rdy;
        logic                     b_rdy;
        logic [ROB_IDX_SIZE-1:0]  a_tag;
        logic [ROB_IDX_SIZE-1:0]  b_tag;
        nzcv_t                    nzcv;
        logic                     n_rdy;
        logic [ROB_IDX_SIZE-1:0]  n_tag;
        logic                     set_nzcv;
        logic [ROB_IDX_SIZE-1:0]  dst;
        logic                     cdb_done;
        logic [ROB_IDX_SIZE-1:0]  cdb_idx;
        logic [GPR_SIZE-1:0]      cdb_val;
        logic                     cdb_set_nzcv;
        nzcv_t                    cdb_nzcv;
        logic                     fu_ready;
    } stim_t;

    // Reference entry: slot 0 = A, 1 = B, 2 = flags.
    typedef struct packed {
        alu_op_t                           op;
        logic [ROB_IDX_SIZE-1:0]           dst;
        logic                              set_nzcv;
        logic [2:0]                        rdy;
        logic [2:0][ROB_IDX_SIZE-1:0]      tag;
        logic [2:0][GPR_SIZE-1:0]          val;
    } m_ent_t;

    typedef struct packed {
        logic [31:0] due;
        logic [95:0] fields;
    } exp_t;

    m_ent_t      mq[$];
    exp_t        sb[$];
    stim_t       s;
    int unsigned cyc      = 0;
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always @(posedge in_clk) cyc <= cyc + 1;

    function automatic void check(string name, logic [95:0] act, logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic logic [95:0] pack_issue(alu_op_t op, logic [GPR_SIZE-1:0] a,
                                               logic [GPR_SIZE-1:0] b,
                                               logic [ROB_IDX_SIZE-1:0] dst,
                                               logic set_nzcv, nzcv_t nzcv);
        return 96'({op, a, b, dst, set_nzcv, nzcv});
    endfunction

    function automatic m_ent_t wake(m_ent_t e);
        for (int k = 0; k < 3; k++) begin
            if (!e.rdy[k] && s.cdb_done && e.tag[k] == s.cdb_idx && (k < 2 || s.cdb_set_nzcv)) begin
                e.rdy[k] = 1'b1;
                e.val[k] = (k == 2) ? GPR_SIZE'(s.cdb_nzcv) : s.cdb_val;
            end
        end
        return e;
    endfunction

    // One clock edge of the station's behaviour, in terms of a plain ordered list.
    function automatic void model_step();
        int     idx = -1;
        bit     accept;
        m_ent_t e;
        exp_t   x;
        if (s.flush) begin
            mq.delete();
            return;
        end
        accept = s.disp_valid && (mq.size() < N);
        if (s.fu_ready)
            foreach (mq[i]) if (idx < 0 && mq[i].rdy == 3'b111) idx = i;
        if (idx >= 0) begin
            x.due    = cyc + 1;
            x.fields = pack_issue(mq[idx].op, mq[idx].val[0], mq[idx].val[1], mq[idx].dst,
                                  mq[idx].set_nzcv, mq[idx].val[2][3:0]);
            sb.push_back(x);
            mq.delete(idx);
        end
        foreach (mq[i]) mq[i] = wake(mq[i]);
        if (accept) begin
            e.op       = s.op;
            e.dst      = s.dst;
            e.set_nzcv = s.set_nzcv;
            e.rdy      = {s.n_rdy, s.b_rdy, s.a_rdy};
            e.tag      = {s.n_tag, s.b_tag, s.a_tag};
            e.val      = {GPR_SIZE'(s.nzcv), s.val_b, s.val_a};
            mq.push_back(wake(e));
        end
    endfunction

    task automatic idle();
        s          = '0;
        s.op       = ALU_PLUS;
        s.a_rdy    = 1'b1;
        s.b_rdy    = 1'b1;
        s.n_rdy    = 1'b1;
        s.fu_ready = 1'b1;
    endtask

    task automatic drive();
        bus.in_flush              = s.flush;
        bus.in_disp_valid         = s.disp_valid;
        bus.in_disp_op            = s.op;
        bus.in_disp_val_a         = s.val_a;
        bus.in_disp_val_b         = s.val_b;
        bus.in_disp_a_ready       = s.a_rdy;
        bus.in_disp_b_ready       = s.b_rdy;
        bus.in_disp_a_tag         = s.a_tag;
        bus.in_disp_b_tag         = s.b_tag;
        bus.in_disp_nzcv          = s.nzcv;
        bus.in_disp_nzcv_ready    = s.n_rdy;
        bus.in_disp_nzcv_tag      = s.n_tag;
        bus.in_disp_set_nzcv      = s.set_nzcv;
        bus.in_disp_dst_rob_index = s.dst;
        bus.in_cdb_done           = s.cdb_done;
        bus.in_cdb_rob_index      = s.cdb_idx;
        bus.in_cdb_value          = s.cdb_val;
        bus.in_cdb_set_nzcv       = s.cdb_set_nzcv;
        bus.in_cdb_nzcv           = s.cdb_nzcv;
        bus.in_fu_ready           = s.fu_ready;
    endtask

    // Called at a negedge: check occupancy, apply s for the coming edge.
    task automatic step();
        check("count", 96'(bus.out_count), 96'(mq.size()));
        check("disp_ready", 96'(bus.out_disp_ready), (mq.size() < N) ? 96'd1 : 96'd0);
        drive();
        model_step();
        @(negedge in_clk);
    endtask

    task automatic idle_steps(int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            idle();
            step();
        end
    endtask

    always @(negedge in_clk) begin : monitor
        exp_t x;
        if (in_rst_n) begin
            if (bus.out_fu_start) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL issue_unexpected: got out_fu_start=1 expected 0 (cycle %0d)", cyc);
                end else begin
                    x = sb.pop_front();
                    check("issue_cycle", 96'(cyc), 96'(x.due));
                    check("issue_fields",
                          pack_issue(bus.out_fu_op, bus.out_fu_val_a, bus.out_fu_val_b,
                                     bus.out_fu_dst_rob_index, bus.out_fu_set_nzcv,
                                     bus.out_fu_nzcv),
                          x.fields);
                end
            end else if (sb.size() != 0 && sb[0].due <= cyc) begin
                n_checks++;
                n_errors++;
                $display("FAIL issue_missing: got out_fu_start=0 expected 1 (due cycle %0d, now %0d)",
                         sb[0].due, cyc);
                x = sb.pop_front();
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        drive();
        in_rst_n = 1'b0;
        #2;
        check("reset_start", 96'(bus.out_fu_start), 96'd0);
        check("reset_val_a", 96'(bus.out_fu_val_a), 96'd0);
        check("reset_op", 96'(bus.out_fu_op), 96'd0);
        check("reset_count", 96'(bus.out_count), 96'd0);
        check("reset_disp_ready", 96'(bus.out_disp_ready), 96'd1);
        @(negedge in_clk);
        @(negedge in_clk);
        in_rst_n = 1'b1;
        idle_steps(2);

        // All-ready PLUS 5,7 issues one cycle after dispatch.
        idle(); s.disp_valid = 1'b1; s.val_a = 5; s.val_b = 7; s.dst = 4'd9; step();
        idle_steps(3);

        // A waits on tag 3, woken by a broadcast of 0x2A.
        idle(); s.disp_valid = 1'b1; s.op = ALU_MINUS; s.a_rdy = 1'b0; s.a_tag = 4'd3;
        s.val_b = 32'h10; s.dst = 4'd1; step();
        idle_steps(2);
        idle(); s.cdb_done = 1'b1; s.cdb_idx = 4'd3; s.cdb_val = 32'h2A; step();
        idle_steps(2);

        // Fill with four waiting entries; a fifth dispatch is refused.
        for (int unsigned i = 0; i < N; i++) begin
            idle(); s.disp_valid = 1'b1; s.op = ALU_AND; s.a_rdy = 1'b0;
            s.a_tag = 4'(8 + i); s.val_b = 32'(200 + i); s.dst = 4'(i); step();
        end
        idle(); s.disp_valid = 1'b1; s.val_a = 32'hDEAD; s.dst = 4'd15; step();
        idle(); s.cdb_done = 1'b1; s.cdb_idx = 4'd10; s.cdb_val = 32'd110; step();
        idle_steps(2);
        // Wake entries 0 and 1 together, hold the ALU off for two cycles.
        idle(); s.fu_ready = 1'b0; s.cdb_done = 1'b1; s.cdb_idx = 4'd8; s.cdb_val = 32'd108; step();
        idle(); s.fu_ready = 1'b0; s.cdb_done = 1'b1; s.cdb_idx = 4'd9; s.cdb_val = 32'd109; step();
        idle(); s.fu_ready = 1'b0; step();
        idle_steps(3);
        idle(); s.cdb_done = 1'b1; s.cdb_idx = 4'd11; s.cdb_val = 32'd111; step();
        idle_steps(2);

        // Flags only wake on a broadcast that carries flags.
        idle(); s.disp_valid = 1'b1; s.n_rdy = 1'b0; s.n_tag = 4'd6; s.set_nzcv = 1'b1; s.dst = 4'd6;
        s.cdb_done = 1'b1; s.cdb_idx = 4'd6; s.cdb_set_nzcv = 1'b0; s.cdb_nzcv = 4'b1111; step();
        idle(); s.cdb_done = 1'b1; s.cdb_idx = 4'd6; s.cdb_set_nzcv = 1'b0; s.cdb_nzcv = 4'b1111; step();
        idle_steps(2);
        idle(); s.cdb_done = 1'b1; s.cdb_idx = 4'd6; s.cdb_set_nzcv = 1'b1; s.cdb_nzcv = 4'b0010; step();
        idle_steps(2);
        idle(); s.disp_valid = 1'b1; s.n_rdy = 1'b0; s.n_tag = 4'd5; s.dst = 4'd5;
        s.cdb_done = 1'b1; s.cdb_idx = 4'd5; s.cdb_set_nzcv = 1'b1; s.cdb_nzcv = 4'b0100; step();
        idle_steps(2);

        // Flush three waiting entries while a dispatch arrives.
        for (int unsigned i = 0; i < 3; i++) begin
            idle(); s.disp_valid = 1'b1; s.b_rdy = 1'b0; s.b_tag = 4'(12 + i); step();
        end
        idle(); s.flush = 1'b1; s.disp_valid = 1'b1; step();
        idle(); s.cdb_done = 1'b1; s.cdb_idx = 4'd12; step();
        idle_steps(2);

        for (int c = 0; c < 3000; c++) begin
            s.flush        = ($urandom_range(0, 63) == 0);
            s.disp_valid   = 1'($urandom_range(0, 1));
            s.op           = alu_op_t'(4'($urandom_range(0, 7)));
            s.val_a        = $urandom;
            s.val_b        = $urandom;
            s.a_rdy        = 1'($urandom_range(0, 1));
            s.b_rdy        = ($urandom_range(0, 3) != 0);
            s.a_tag        = 4'($urandom_range(0, 7));
            s.b_tag        = 4'($urandom_range(0, 7));
            s.nzcv         = 4'($urandom_range(0, 15));
            s.n_rdy        = ($urandom_range(0, 3) != 0);
            s.n_tag        = 4'($urandom_range(0, 7));
            s.set_nzcv     = 1'($urandom_range(0, 1));
            s.dst          = 4'($urandom_range(0, 15));
            s.cdb_done     = ($urandom_range(0, 9) < 6);
            s.cdb_idx      = 4'($urandom_range(0, 7));
            s.cdb_val      = $urandom;
            s.cdb_set_nzcv = 1'($urandom_range(0, 1));
            s.cdb_nzcv     = 4'($urandom_range(0, 15));
            s.fu_ready     = ($urandom_range(0, 9) < 7);
            step();
        end

        idle(); s.flush = 1'b1; step();
        idle_steps(2);

        // Asynchronous reset while an issue is on the outputs.
        idle(); s.disp_valid = 1'b1; s.val_a = 32'h11; s.val_b = 32'h22; s.dst = 4'd3; step();
        idle();
        drive();
        @(posedge in_clk);
        #2;
        check("pre_reset_start", 96'(bus.out_fu_start), 96'd1);
        check("pre_reset_val_a", 96'(bus.out_fu_val_a), 96'h11);
        in_rst_n = 1'b0;
        #1;
        check("async_start", 96'(bus.out_fu_start), 96'd0);
        check("async_val_a", 96'(bus.out_fu_val_a), 96'd0);
        check("async_val_b", 96'(bus.out_fu_val_b), 96'd0);
        check("async_dst", 96'(bus.out_fu_dst_rob_index), 96'd0);
        check("async_count", 96'(bus.out_count), 96'd0);
        check("async_disp_ready", 96'(bus.out_disp_ready), 96'd1);
        mq.delete();
        sb.delete();
        @(negedge in_clk);
        in_rst_n = 1'b1;
        idle_steps(3);

        check("scoreboard_drained", 96'(sb.size()), 96'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
